// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - sequential N x N multiplier driving an external adder
// Runs unsigned shift-add or radix-2 Booth, one iteration per cycle, for N cycles.
module mult_sequencer #(
  parameter int N = 8
) (
  input  logic [0:0]     Clock,
  input  logic [0:0]     Reset,
  input  logic [0:0]     Start,
  input  logic [0:0]     Signed,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic [N-1:0]   Adder_A,
  output logic [N-1:0]   Adder_B,
  output logic [0:0]     Adder_Sub,
  input  logic [N-1:0]   Adder_Sum,
  input  logic [0:0]     Adder_Carry,
  input  logic [0:0]     Adder_Overflow,
  output logic [0:0]     Busy,
  output logic [0:0]     Done,
  output logic [2*N-1:0] Product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   m_q, m_d;
  logic           qm1_q, qm1_d;
  logic           sgn_q, sgn_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;

  logic           op;
  logic           fill;
  logic [N-1:0]   a_new;
  logic [N-1:0]   a_shift;
  logic [N-1:0]   q_shift;

  // Datapath for one iteration. In signed mode the true sign of the N+1 bit
  // result is Sum[N-1]^Overflow, which keeps M = -2^(N-1) exact.
  always_comb begin
    op      = sgn_q ? (q_q[0] ^ qm1_q) : q_q[0];
    a_new   = op ? Adder_Sum : a_q;
    fill    = 1'b0;
    if (sgn_q) begin
      fill = op ? (Adder_Sum[N-1] ^ Adder_Overflow) : a_q[N-1];
    end else begin
      fill = op & Adder_Carry;
    end
    a_shift = {fill, a_new[N-1:1]};
    q_shift = {a_new[0], q_q[N-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    sgn_d     = sgn_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          m_d     = Multiplicand;
          q_d     = Multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          sgn_d   = Signed;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_shift;
        q_d     = q_shift;
        if (sgn_q) begin
          qm1_d = q_q[0];
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          product_d = {a_shift, q_shift};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      sgn_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      sgn_q     <= sgn_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign Adder_A   = a_q;
  assign Adder_B   = m_q;
  assign Adder_Sub = (state_q == S_RUN) && sgn_q && q_q[0] && !qm1_q;
  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign Product   = product_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - bench for mult_sequencer (N=8 directed + N=4 sweep)
// Each DUT is wired to a behavioural ripple adder standing in for the team adder.
module tb_mult_sequencer;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // N = 8 instance and its adder
  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic [7:0]  a8, b8, sum8;
  logic        sub8, cy8, ov8, busy8, done8;
  logic [15:0] prod8;
  logic [8:0]  add8_w;
  assign add8_w = {1'b0, a8} + {1'b0, (sub8 ? ~b8 : b8)} + {8'd0, sub8};
  assign sum8   = add8_w[7:0];
  assign cy8    = add8_w[8];
  assign ov8    = (a8[7] == (sub8 ? ~b8[7] : b8[7])) && (add8_w[7] != a8[7]);

  mult_sequencer #(.N(8)) u8 (
    .Clock(Clock), .Reset(Reset), .Start(st8), .Signed(sg8),
    .Multiplicand(mc8), .Multiplier(mp8),
    .Adder_A(a8), .Adder_B(b8), .Adder_Sub(sub8),
    .Adder_Sum(sum8), .Adder_Carry(cy8), .Adder_Overflow(ov8),
    .Busy(busy8), .Done(done8), .Product(prod8)
  );

  // N = 4 instance and its adder
  logic        st4 = 1'b0, sg4 = 1'b0;
  logic [3:0]  mc4 = '0, mp4 = '0;
  logic [3:0]  a4, b4, sum4;
  logic        sub4, cy4, ov4, busy4, done4;
  logic [7:0]  prod4;
  logic [4:0]  add4_w;
  assign add4_w = {1'b0, a4} + {1'b0, (sub4 ? ~b4 : b4)} + {4'd0, sub4};
  assign sum4   = add4_w[3:0];
  assign cy4    = add4_w[4];
  assign ov4    = (a4[3] == (sub4 ? ~b4[3] : b4[3])) && (add4_w[3] != a4[3]);

  mult_sequencer #(.N(4)) u4 (
    .Clock(Clock), .Reset(Reset), .Start(st4), .Signed(sg4),
    .Multiplicand(mc4), .Multiplier(mp4),
    .Adder_A(a4), .Adder_B(b4), .Adder_Sub(sub4),
    .Adder_Sum(sum4), .Adder_Carry(cy4), .Adder_Overflow(ov4),
    .Busy(busy4), .Done(done4), .Product(prod4)
  );

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] m, input logic [7:0] q);
    logic signed [15:0] sm, sq;
    sm = $signed(m);
    sq = $signed(q);
    if (s) return 16'(sm * sq);
    return {8'd0, m} * {8'd0, q};
  endfunction

  function automatic logic [7:0] ref4(input logic s, input logic [3:0] m, input logic [3:0] q);
    logic signed [7:0] sm, sq;
    sm = $signed(m);
    sq = $signed(q);
    if (s) return 8'(sm * sq);
    return {4'd0, m} * {4'd0, q};
  endfunction

  // Booth subtracts on multiplier bit pair (bit k, bit k-1) = (1,0), bit -1 being 0.
  function automatic logic exp_sub(input int p, input logic s, input logic [7:0] q);
    if (p < 1 || p > 8 || !s) return 1'b0;
    if (p == 1) return q[0];
    return q[3'(p - 1)] && !q[3'(p - 2)];
  endfunction

  // Timeline model of the N=8 DUT: phase 0 idle, 1..8 busy, 9 done.
  int          ph = 0;
  logic [7:0]  mm = '0, mq = '0;
  logic        ms = 1'b0;
  logic [15:0] mprod = '0;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ph <= 0; mm <= '0; mq <= '0; ms <= 1'b0; mprod <= '0;
    end else if (ph == 0) begin
      if (st8) begin
        ph <= 1; mm <= mc8; mq <= mp8; ms <= sg8;
      end
    end else if (ph == 8) begin
      ph <= 9;
      mprod <= ref8(ms, mm, mq);
    end else if (ph == 9) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge Clock) begin
    if (Reset) begin
      chk("cyc_busy", 32'(busy8), 32'(ph >= 1 && ph <= 8));
      chk("cyc_done", 32'(done8), 32'(ph == 9));
      chk("cyc_product", 32'(prod8), 32'(mprod));
      chk("cyc_adder_sub", 32'(sub8), 32'(exp_sub(ph, ms, mq)));
      chk("cyc_adder_b", 32'(b8), 32'(mm));
    end
  end

  task automatic run8(input logic s, input logic [7:0] m, input logic [7:0] q, input logic hold,
                      output logic [15:0] prod, output int edges, output int busy_cycles);
    sg8 = s; mc8 = m; mp8 = q; st8 = 1'b1;
    @(posedge Clock); #1;
    edges = 1;
    busy_cycles = 0;
    if (hold) begin
      mc8 = 8'h07; mp8 = 8'h09; sg8 = ~s;
    end else begin
      st8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom); sg8 = ~s;
    end
    while (!done8 && edges < 30) begin
      if (busy8) busy_cycles++;
      @(posedge Clock); #1;
      edges++;
    end
    prod = prod8;
    @(posedge Clock); #1;
    st8 = 1'b0;
  endtask

  logic [15:0] p;
  int          e, b, dcount;

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_product", 32'(prod8), 32'd0);
    chk("rst_adder_sub", 32'(sub8), 32'd0);
    chk("rst_adder_a", 32'(a8), 32'd0);
    chk("rst_adder_b", 32'(b8), 32'd0);
    Reset = 1'b1;

    run8(1'b0, 8'd255, 8'd255, 1'b0, p, e, b);
    chk("u255x255_prod", 32'(p), 32'h0000FE01);
    chk("u255x255_done_edge", 32'(e), 32'd9);
    chk("u255x255_busy_cycles", 32'(b), 32'd8);

    run8(1'b1, 8'h80, 8'h80, 1'b0, p, e, b);
    chk("s_m128xm128_prod", 32'(p), 32'h00004000);
    run8(1'b1, 8'hFD, 8'h05, 1'b0, p, e, b);
    chk("s_m3x5_prod", 32'(p), 32'h0000FFF1);
    run8(1'b1, 8'h7F, 8'h80, 1'b0, p, e, b);
    chk("s_127xm128_prod", 32'(p), 32'h0000C080);
    chk("s_127xm128_done_edge", 32'(e), 32'd9);

    run8(1'b0, 8'h00, 8'hA5, 1'b0, p, e, b);
    chk("u0xa5_prod", 32'(p), 32'h00000000);
    chk("u0xa5_done_edge", 32'(e), 32'd9);

    run8(1'b0, 8'd10, 8'd20, 1'b1, p, e, b);
    chk("restart_ignored_prod", 32'(p), 32'h000000C8);
    repeat (2) @(posedge Clock);
    #1;
    chk("restart_ignored_idle", 32'(busy8), 32'd0);
    chk("restart_ignored_hold", 32'(prod8), 32'h000000C8);

    sg8 = 1'b0; mc8 = 8'd100; mp8 = 8'd3; st8 = 1'b1;
    @(posedge Clock); #1;
    st8 = 1'b0;
    repeat (3) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_product", 32'(prod8), 32'd0);
    chk("abort_adder_sub", 32'(sub8), 32'd0);
    chk("abort_adder_a", 32'(a8), 32'd0);
    chk("abort_adder_b", 32'(b8), 32'd0);
    dcount = 0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    run8(1'b0, 8'd3, 8'd4, 1'b0, p, e, b);
    chk("post_reset_prod", 32'(p), 32'h0000000C);
    chk("post_reset_done_edge", 32'(e), 32'd9);
    repeat (12) begin
      @(posedge Clock); #1;
      if (done8) dcount++;
    end
    chk("no_spurious_done", 32'(dcount), 32'd0);

    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 16; m++) begin
        for (int q = 0; q < 16; q++) begin
          sg4 = 1'(s); mc4 = 4'(m); mp4 = 4'(q); st4 = 1'b1;
          @(posedge Clock); #1;
          st4 = 1'b0;
          e = 1;
          while (!done4 && e < 20) begin
            @(posedge Clock); #1;
            e++;
          end
          chk("sweep4_done_edge", 32'(e), 32'd5);
          chk("sweep4_prod", 32'(prod4), 32'(ref4(1'(s), 4'(m), 4'(q))));
          @(posedge Clock); #1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand width; the product is 2N bits.
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port Signed  input  1  1 = two's-complement Booth, 0 = unsigned shift-add; latched with Start.
REQ-006 SHALL have port Multiplicand  input  N  operand M.
REQ-007 SHALL have port Multiplier  input  N  operand Q.
REQ-008 SHALL have port Adder_A  output  N  to adder First_Input; always equals accumulator A.
REQ-009 SHALL have port Adder_B  output  N  to adder Second_Input; always equals latched M.
REQ-010 SHALL have port Adder_Sub  output  1  to adder Sub; 1 only in RUN with Signed mode and (Q0,Qm1)=(1,0).
REQ-011 SHALL have port Adder_Sum  input  N  from adder Adder_Output.
REQ-012 SHALL have port Adder_Carry  input  1  from adder Carry.
REQ-013 SHALL have port Adder_Overflow  input  1  from adder Overflow.
REQ-014 SHALL have port Busy  output  1  high in RUN.
REQ-015 SHALL have port Done  output  1  one-cycle pulse when Product updates.
REQ-016 SHALL have port Product  output  2N  registered result; held until the next completion.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL, in IDLE with Start=1, load M=Multiplicand, Q=Multiplier, A=0, Qm1=0, count=0, latch Signed, and enter RUN.
REQ-019 SHALL perform exactly one iteration per RUN cycle, for N cycles.
REQ-020 SHALL, in unsigned mode, set op=Q0 (add, Sub=0), Anew=op?Adder_Sum:A, and fill bit c=op?Adder_Carry:0.
REQ-021 SHALL, in signed mode with (Q0,Qm1)=01, add; with 10, subtract; with 00/11, leave Anew=A.
REQ-022 SHALL, in signed mode, set fill bit c=Adder_Sum[N-1]^Adder_Overflow when adding or subtracting, else A[N-1].
REQ-023 SHALL shift each iteration as A<={c,Anew[N-1:1]}, Q<={Anew[0],Q[N-1:1]}, Qm1<=Q0 (Qm1 updates in signed mode only), count<=count+1.
REQ-024 SHALL, on the edge completing iteration N, load Product={A,Q} (post-shift values), set Done=1, and enter DONE.
REQ-025 SHALL return from DONE to IDLE unconditionally after one cycle; Done=0 outside DONE.
REQ-026 SHALL give latency of Start edge to Product valid / Done high of N+1 edges; the next Start is accepted no earlier than the cycle after DONE.
REQ-027 SHALL ignore Start in RUN and DONE; operand or Signed changes after the Start edge SHALL NOT affect the result.
REQ-028 SHALL produce the exact 2N-bit product for all operands, including signed M = -2^(N-1) (handled via Overflow).
REQ-029 SHALL use no arithmetic other than the external adder, apart from the count incrementer.

Reset
REQ-030 SHALL, on Reset=0 at any time including mid-RUN, immediately force IDLE, A=Q=M=Qm1=count=0, Product=0, Busy=0, Done=0, Adder_Sub=0.
REQ-031 SHALL NOT assert Done or update Product for an operation aborted by reset; it SHALL accept Start in the first cycle after reset release.

Verification
REQ-032 SHALL verify: unsigned 255 x 255 -> Product=0xFE01, Done pulse exactly N+1=9 edges after the Start edge, Busy high 8 cycles.
REQ-033 SHALL verify: signed -128 x -128 -> Product=0x4000; signed -3 x 5 -> 0xFFF1; signed 127 x -128 -> 0xC080.
REQ-034 SHALL verify: unsigned 0 x 0xA5 -> Product=0x0000, Done pulses, Adder_Sub stays 0 throughout.
REQ-035 SHALL verify: Start re-asserted with new operands during RUN and DONE -> ignored; Product equals the first operation's result.
REQ-036 SHALL verify: Reset pulsed at RUN cycle 4 -> all outputs 0 asynchronously, no Done; Start 3 x 4 after release -> Product=0x000C.
REQ-037 SHALL verify: exhaustive N=4 sweep over both modes of all 256 operand pairs, connected to the team adder, against a reference model.
